// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: asynchronous serial receiver (8N1 by default) feeding the
// snake game core. Bytes are presented on dataRX with a one-cycle WR_RX pulse;
// framing errors and line activity are reported for the debug LEDs.
// Optional feature: define UART_PARITY_EN to insert a parity bit between the
// data bits and the stop bit (PARITY_ODD selects odd or even sense).
module uart_rx_cmd #(
    parameter int CLKS_PER_BIT = 217,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] dataRX,
    output logic       WR_RX,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [9:0] BIT_LAST  = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0] HALF_LAST = 10'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic       rx_meta, rx_s;
    logic [9:0] cnt, cnt_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] data_q, data_nxt;
    logic       wr_q, wr_nxt;
    logic       ferr_q, ferr_nxt;
`ifdef UART_PARITY_EN
    logic       perr_q, perr_nxt;
    logic       par_bad, par_bad_nxt;
`else
    logic       unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    // Two-flop synchronizer; the line idles high so reset loads ones
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q  <= 1'b0;
            par_bad <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shift  <= shift_nxt;
            data_q <= data_nxt;
            wr_q   <= wr_nxt;
            ferr_q <= ferr_nxt;
`ifdef UART_PARITY_EN
            perr_q  <= perr_nxt;
            par_bad <= par_bad_nxt;
`endif
        end
    end

    // Next-state logic: sample only at the start-bit centre and each bit centre
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 10'd1;
        idx_nxt   = idx;
        shift_nxt = shift;
        data_nxt  = data_q;
        wr_nxt    = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_PARITY_EN
        perr_nxt    = 1'b0;
        par_bad_nxt = par_bad;
`endif
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
`ifdef UART_PARITY_EN
                par_bad_nxt = 1'b0;
`endif
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DATA;
                        idx_nxt   = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    idx_nxt        = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    par_bad_nxt = rx_s ^ (^shift) ^ PARITY_ODD;
                    state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
`ifdef UART_PARITY_EN
                    perr_nxt = par_bad;
`endif
                    if (rx_s) begin
                        state_nxt = S_IDLE;
`ifdef UART_PARITY_EN
                        if (!par_bad) begin
                            wr_nxt   = 1'b1;
                            data_nxt = shift;
                        end
`else
                        wr_nxt   = 1'b1;
                        data_nxt = shift;
`endif
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign dataRX    = data_q;
    assign WR_RX     = wr_q;
    assign frame_err = ferr_q;
`ifdef UART_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif
    assign busy = (state != S_IDLE);

endmodule
